// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums a configured number of signed beats per output,
// then rounds half-up, arithmetic-shifts, optionally applies ReLU and saturates.
module psum_accumulator #(
    parameter int IN_WIDTH    = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int MAX_PASSES  = 16,
    parameter int PASS_WIDTH  = $clog2(MAX_PASSES) + 1,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic        [PASS_WIDTH-1:0]  cfg_num_pass,
    input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic                          cfg_relu,
    input  logic                          soft_clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [IN_WIDTH-1:0]    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [PASS_WIDTH-1:0]    MAX_PASS_V = PASS_WIDTH'(MAX_PASSES);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX   = (ACC_WIDTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN   = -OUT_MAX - 1;

    state_t state;
    state_t state_next;

    logic signed [ACC_WIDTH-1:0]   acc;
    logic        [PASS_WIDTH-1:0]  cnt;
    logic        [PASS_WIDTH-1:0]  num_pass;
    logic        [SHIFT_WIDTH-1:0] shift;
    logic                          relu;

    logic                          accept;
    logic                          last_beat;
    logic        [PASS_WIDTH-1:0]  cnt_inc;
    logic        [PASS_WIDTH-1:0]  num_pass_clamped;
    logic signed [ACC_WIDTH-1:0]   in_ext;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [ACC_WIDTH:0]     sum_wide;
    logic signed [ACC_WIDTH:0]     round_bias;
    logic signed [ACC_WIDTH:0]     biased;
    logic signed [ACC_WIDTH:0]     shifted;
    logic signed [ACC_WIDTH:0]     relu_out;
    logic signed [OUT_WIDTH-1:0]   quantized;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic; soft_clear overrides every other event
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (cfg_start)            state_next = ACCUM;
            ACCUM:   if (in_valid && last_beat) state_next = EMIT;
            EMIT:    if (out_ready)            state_next = ACCUM;
            default:                           state_next = IDLE;
        endcase
        if (soft_clear) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs depend on the state register only
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE:    busy      = 1'b0;
            ACCUM:   in_ready  = 1'b1;
            EMIT:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Config clamping and beat bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        num_pass_clamped = cfg_num_pass;
        if (cfg_num_pass == '0) begin
            num_pass_clamped = PASS_WIDTH'(1);
        end else if (cfg_num_pass > MAX_PASS_V) begin
            num_pass_clamped = MAX_PASS_V;
        end
    end

    assign accept    = in_valid && (state == ACCUM);
    assign cnt_inc   = cnt + PASS_WIDTH'(1);
    assign last_beat = (cnt_inc == num_pass);

    // ------------------------------------------------------------------
    // Quantization of the final sum, in the same cycle as the last beat
    // ------------------------------------------------------------------
    assign in_ext   = {{(ACC_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign acc_sum  = acc + in_ext;
    assign sum_wide = {acc[ACC_WIDTH-1], acc} + {in_ext[ACC_WIDTH-1], in_ext};

    always_comb begin
        round_bias = '0;
        if (shift != '0) begin
            round_bias = (ACC_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
        end
    end

    assign biased   = sum_wide + round_bias;
    assign shifted  = biased >>> shift;
    assign relu_out = (relu && (shifted < 0)) ? '0 : shifted;

    always_comb begin
        if (relu_out > OUT_MAX) begin
            quantized = OUT_MAX[OUT_WIDTH-1:0];
        end else if (relu_out < OUT_MIN) begin
            quantized = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            quantized = relu_out[OUT_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            num_pass <= '0;
            shift    <= '0;
            relu     <= 1'b0;
            out_data <= '0;
        end else if (soft_clear) begin
            // out_data deliberately keeps its last value across an abort
            acc <= '0;
            cnt <= '0;
        end else if ((state == IDLE) && cfg_start) begin
            num_pass <= num_pass_clamped;
            shift    <= cfg_shift;
            relu     <= cfg_relu;
            acc      <= '0;
            cnt      <= '0;
        end else if (accept) begin
            if (last_beat) begin
                out_data <= quantized;
                acc      <= '0;
                cnt      <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Partial-sum accumulator directly downstream of the combinational signed kernel adder. Each accepted beat is one signed adder result (one input-channel group). The block sums a configured number of beats per output element, then rounds, right-shifts, optionally applies ReLU, and saturates to the output activation width. The result is presented on a valid/ready port to the output buffer writer.

## Interface
Parameters:
- IN_WIDTH, 16, width of the signed adder result (matches the adder OUT_WIDTH)
- ACC_WIDTH, 32, signed accumulator width; must be ≥ IN_WIDTH + $clog2(MAX_PASSES), so the accumulator never overflows
- OUT_WIDTH, 8, signed output activation width
- MAX_PASSES, 16, maximum beats per output element
- PASS_WIDTH, $clog2(MAX_PASSES)+1, width of cfg_num_pass
- SHIFT_WIDTH, 5, width of cfg_shift

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle pulse; latches the cfg_* inputs; honoured only in IDLE
- cfg_num_pass  in  PASS_WIDTH  beats per output; 0 is treated as 1; values > MAX_PASSES clamp to MAX_PASSES
- cfg_shift  in  SHIFT_WIDTH  arithmetic right shift applied to the sum
- cfg_relu  in  1  1 = clamp negative results to 0
- soft_clear  in  1  synchronous abort to IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  accumulator ready
- in_data  in  IN_WIDTH  signed adder result
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  OUT_WIDTH  signed, quantized result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCUM, EMIT.
- IDLE:
  - in_ready=0, out_valid=0.
  - cfg_start latches the config (with the clamping rules above), clears acc and cnt, and moves to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&in_ready adds sign-extended in_data to acc and increments cnt. Cycles without in_valid are bubbles and do not count.
  - On the beat where cnt+1 == num_pass, compute from s = acc + in_data:
    - r = (s + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed at ACC_WIDTH+1 bits. This is round-half-up.
    - If relu, r = max(r, 0).
    - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register r into out_data, clear acc and cnt, and go to EMIT.
- EMIT:
  - out_valid=1 and in_ready=0. out_data is held stable until out_ready.
  - On out_valid&out_ready, go to ACCUM with the same latched config. Processing of successive output elements continues without a new cfg_start.
- cfg_start outside IDLE is ignored. cfg_* inputs are don't-care except in the cfg_start cycle.
- soft_clear takes priority over every other event in any state:
  - Next cycle: state IDLE, acc=0, cnt=0, out_valid=0.
  - out_data keeps its last value.
  - If soft_clear coincides with an input or output handshake, that handshake is discarded.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, acc=0, cnt=0, config registers=0.
- Reset mid-operation discards the partial sum. A new cfg_start is required after rst_n is released.
- in_ready and out_valid are pure functions of the state register; there is no combinational path from in_valid or out_ready.
- Latency: last input beat accepted at cycle t gives out_valid=1 from cycle t+1.
- Output handshake at cycle e gives in_ready=1 from cycle e+1.
- Minimum period per output is num_pass+1 cycles; num_pass=1 gives one result every 2 cycles.
- The final beat and the quantization happen in the same cycle; there is no extra pipeline stage.
- busy rises the cycle after cfg_start and falls the cycle after soft_clear.

## Test plan
- Basic sum: cfg_num_pass=3, shift=0, relu=0; beats 10, -3, 5 with no bubbles.
  - Required: out_data=12; out_valid rises one cycle after the third beat; in_ready=0 while out_valid=1.
- Saturation and ReLU: num_pass=2, shift=0.
  - Beats 200, 100 → 127.
  - Beats -200, -100 → -128.
  - Same negative beats with relu=1 → 0.
- Rounding: num_pass=1, shift=2.
  - Input 6 → 2.
  - Input 5 → 1.
  - Input -6 → -1.
  - Input -7 → -2.
  - cfg_num_pass=0 behaves exactly as 1.
- Backpressure and bubbles: num_pass=2 with in_valid toggled 1,0,0,1 (beats 4, 4).
  - Result 8 appears only after the second valid beat.
  - Hold out_ready=0 for 5 cycles while in_valid=1 with data 99: out_data stays 8, out_valid stays 1, and 99 is not accumulated.
  - After the handshake, beats 1, 1 → 2, confirming acc restarted at 0.
- Abort and reset:
  - After 1 of 3 beats, pulse soft_clear: next cycle busy=0 and out_valid=0.
  - A new cfg_start with beats 1, 1, 1 → 3.
  - Repeat the sequence with rst_n pulsed low mid-ACCUM: all outputs go to their reset values immediately.
  - Also check that cfg_start asserted during ACCUM does not change the latched config.
